barrel_shifter_pipe: RTL and testbench

//  Parametrised, pipelined barrel shifter. One shift/rotate operation is accepted per cycle with a

---
 rtl/barrel_shifter_pipe_pkg.sv | 31 +++
 rtl/barrel_shifter_pipe_if.sv | 31 +++
 rtl/barrel_shifter_pipe_stage.sv | 82 ++++++++
 rtl/barrel_shifter_pipe.sv | 86 ++++++++
 tb/tb_barrel_shifter_pipe.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/barrel_shifter_pipe_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
// Optional feature macro: BARREL_SHIFTER_FLAGS_EN (carry/zero flags).
package shifter_pkg;

  localparam int unsigned SH_MODE_W = 3;

  typedef enum logic [SH_MODE_W-1:0] {
    SH_LSL = 3'b000,
    SH_LSR = 3'b001,
    SH_ASR = 3'b010,
    SH_ROL = 3'b011,
    SH_ROR = 3'b100,
    SH_ASL = 3'b101
  } shmode_t;

  // Left-going modes: ASL produces the same result as LSL.
  function automatic logic is_left(input shmode_t m);
    return (m == SH_LSL) || (m == SH_ASL) || (m == SH_ROL);
  endfunction

  function automatic logic is_rotate(input shmode_t m);
    return (m == SH_ROL) || (m == SH_ROR);
  endfunction

  // Codes 110/111 pass data through unchanged with no carry.
  function automatic logic is_reserved(input shmode_t m);
    return !((m == SH_LSL) || (m == SH_LSR) || (m == SH_ASR) ||
             (m == SH_ROL) || (m == SH_ROR) || (m == SH_ASL));
  endfunction

endpackage

// File: rtl/barrel_shifter_pipe_if.sv
// Operation/result handshake bundle for barrel_shifter_pipe.
// master = operation producer / result consumer, slave = the shifter.
interface barrel_shifter_pipe_if
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned SHAMT_W = $clog2(WIDTH);

  logic               in_valid;
  logic               in_ready;
  shmode_t            in_mode;
  logic [SHAMT_W-1:0] in_shamt;
  logic [WIDTH-1:0]   in_data;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_carry;
  logic               out_zero;

  modport master (
    output in_valid, in_mode, in_shamt, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_carry, out_zero
  );

  modport slave (
    input  in_valid, in_mode, in_shamt, in_data, out_ready,
    output in_ready, out_valid, out_data, out_carry, out_zero
  );

endinterface

// File: rtl/barrel_shifter_pipe_stage.sv
// One log2 stage of the barrel shifter: shifts/rotates by DIST when its
// amount bit is set, then registers the result behind a valid/ready slot.
// Optional feature macro: BARREL_SHIFTER_FLAGS_EN (carry register built).
module shift_stage
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIST  = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       up_valid,
  output logic                       up_ready_c,
  input  shmode_t                    up_mode,
  input  logic [$clog2(WIDTH)-1:0]   up_shamt,
  input  logic [WIDTH-1:0]           up_data,
  input  logic                       up_carry,
  output logic                       dn_valid,
  input  logic                       dn_ready,
  output shmode_t                    dn_mode,
  output logic [$clog2(WIDTH)-1:0]   dn_shamt,
  output logic [WIDTH-1:0]           dn_data,
  output logic                       dn_carry
);
  localparam int unsigned SHAMT_W = $clog2(WIDTH);
  localparam int unsigned K       = $clog2(DIST);

  logic [WIDTH-1:0] shifted;

  // Stage slot accepts when empty or when the downstream slot drains.
  assign up_ready_c = !dn_valid || dn_ready;

  // Conditional shift/rotate by DIST selected by amount bit K.
  always_comb begin
    shifted = up_data;
    if (!is_reserved(up_mode) && up_shamt[K]) begin
      if (is_rotate(up_mode)) begin
        if (is_left(up_mode)) shifted = (up_data << DIST) | (up_data >> (WIDTH - DIST));
        else                  shifted = (up_data >> DIST) | (up_data << (WIDTH - DIST));
      end else if (is_left(up_mode)) begin
        shifted = up_data << DIST;
      end else if (up_mode == SH_ASR) begin
        shifted = WIDTH'($signed(up_data) >>> DIST);
      end else begin
        shifted = up_data >> DIST;
      end
    end
  end

  // Handshake register; payload only updates when a valid op is loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dn_valid <= 1'b0;
      dn_mode  <= SH_LSL;
      dn_shamt <= SHAMT_W'(0);
      dn_data  <= WIDTH'(0);
    end else if (up_ready_c) begin
      dn_valid <= up_valid;
      if (up_valid) begin
        dn_mode  <= up_mode;
        dn_shamt <= up_shamt;
        dn_data  <= shifted;
      end
    end
  end

`ifdef BARREL_SHIFTER_FLAGS_EN
  // Carry is fixed at stage 0 and simply travels with the data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dn_carry <= 1'b0;
    end else if (up_ready_c && up_valid) begin
      dn_carry <= up_carry;
    end
  end
`else
  logic unused_carry;
  assign unused_carry = up_carry;
  assign dn_carry     = 1'b0;
`endif

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined run-time barrel shifter: one registered log2 stage per
// shift-amount bit, valid/ready flow control, 1 op per cycle throughput.
// Optional feature macro: BARREL_SHIFTER_FLAGS_EN (out_carry/out_zero).
module barrel_shifter_pipe
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  barrel_shifter_pipe_if.slave bus
);
  localparam int unsigned SHAMT_W = $clog2(WIDTH);
  localparam int unsigned STAGES  = SHAMT_W;

  logic               valid_a [STAGES+1];
  logic               ready_a [STAGES+1];
  shmode_t            mode_a  [STAGES+1];
  logic [SHAMT_W-1:0] shamt_a [STAGES+1];
  logic [WIDTH-1:0]   data_a  [STAGES+1];
  logic               carry_a [STAGES+1];
  logic               carry0_c;

  // Pipeline entry and exit wiring.
  assign valid_a[0]      = bus.in_valid;
  assign mode_a[0]       = bus.in_mode;
  assign shamt_a[0]      = bus.in_shamt;
  assign data_a[0]       = bus.in_data;
  assign carry_a[0]      = carry0_c;
  assign bus.in_ready    = ready_a[0];
  assign ready_a[STAGES] = bus.out_ready;
  assign bus.out_valid   = valid_a[STAGES];
  assign bus.out_data    = data_a[STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    shift_stage #(
      .WIDTH (WIDTH),
      .DIST  (2**k)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .up_valid   (valid_a[k]),
      .up_ready_c (ready_a[k]),
      .up_mode    (mode_a[k]),
      .up_shamt   (shamt_a[k]),
      .up_data    (data_a[k]),
      .up_carry   (carry_a[k]),
      .dn_valid   (valid_a[k+1]),
      .dn_ready   (ready_a[k+1]),
      .dn_mode    (mode_a[k+1]),
      .dn_shamt   (shamt_a[k+1]),
      .dn_data    (data_a[k+1]),
      .dn_carry   (carry_a[k+1])
    );
  end

`ifdef BARREL_SHIFTER_FLAGS_EN
  logic [SHAMT_W-1:0] idx_left;
  logic [SHAMT_W-1:0] idx_right;
  logic               unused_tail;

  // Bit index of the last bit leaving the word: WIDTH-shamt or shamt-1.
  assign idx_left  = SHAMT_W'(0) - bus.in_shamt;
  assign idx_right = bus.in_shamt - SHAMT_W'(1);

  // Carry from the original operand; none for shamt 0 or reserved modes.
  always_comb begin
    carry0_c = 1'b0;
    if ((bus.in_shamt != SHAMT_W'(0)) && !is_reserved(bus.in_mode)) begin
      carry0_c = is_left(bus.in_mode) ? bus.in_data[idx_left] : bus.in_data[idx_right];
    end
  end

  assign bus.out_carry = carry_a[STAGES];
  assign bus.out_zero  = valid_a[STAGES] && (data_a[STAGES] == WIDTH'(0));
  assign unused_tail   = ^{mode_a[STAGES], shamt_a[STAGES]};
`else
  logic unused_tail;

  assign carry0_c      = 1'b0;
  assign bus.out_carry = 1'b0;
  assign bus.out_zero  = 1'b0;
  assign unused_tail   = ^{mode_a[STAGES], shamt_a[STAGES], carry_a[STAGES]};
`endif

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Directed + short random bench for barrel_shifter_pipe (WIDTH=8) with a
// scoreboard queue of expected results.
module tb_barrel_shifter_pipe;
  import shifter_pkg::*;

  typedef struct packed {
    logic [7:0] data;
    logic       carry;
    logic       zero;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  barrel_shifter_pipe_if #(.WIDTH(8)) bus ();
  barrel_shifter_pipe #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   out_cnt    = 0;
  int   sent_cnt   = 0;
  bit   saw_stall  = 0;
  bit   held       = 0;
  exp_t held_val;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference result built from a doubled word instead of staged shifts.
  function automatic exp_t model(input logic [2:0] m, input logic [2:0] s, input logic [7:0] d);
    exp_t       e;
    logic [15:0] dd;
    logic [15:0] sx;
    logic [15:0] t;
    int          si;
    dd = {d, d};
    sx = {{8{d[7]}}, d};
    si = int'(s);
    case (m)
      3'd0, 3'd5: t = {8'h00, d} << si;
      3'd1:       t = {8'h00, d} >> si;
      3'd2:       t = sx >> si;
      3'd3:       t = dd >> (8 - si);
      3'd4:       t = dd >> si;
      default:    t = {8'h00, d};
    endcase
    e.data  = t[7:0];
    e.carry = 1'b0;
    if (si != 0 && m <= 3'd5) begin
      if (m == 3'd0 || m == 3'd3 || m == 3'd5) e.carry = d[8 - si];
      else                                      e.carry = d[si - 1];
    end
    e.zero = (e.data == 8'h00);
`ifndef BARREL_SHIFTER_FLAGS_EN
    e.carry = 1'b0;
    e.zero  = 1'b0;
`endif
    return e;
  endfunction

  // Present one op and hold it until accepted; expected result queued on accept.
  task automatic send(input logic [2:0] m, input logic [2:0] s, input logic [7:0] d);
    int n;
    bit done;
    n    = 0;
    done = 0;
    bus.in_valid = 1'b1;
    bus.in_mode  = shmode_t'(m);
    bus.in_shamt = s;
    bus.in_data  = d;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb.push_back(model(m, s, d));
        sent_cnt++;
        done = 1;
      end else begin
        saw_stall = 1;
      end
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 200) begin
        check("accept_timeout", 32'd0, 32'd1);
        done = 1;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  // Output side: stability while stalled, then in-order scoreboard compare.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid) begin
      if (held) check("hold_stable", {23'd0, bus.out_data, bus.out_carry, bus.out_zero},
                      {23'd0, held_val});
      if (bus.out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("out_data",  32'(bus.out_data),  32'(e.data));
          check("out_carry", 32'(bus.out_carry), 32'(e.carry));
          check("out_zero",  32'(bus.out_zero),  32'(e.zero));
        end
        out_cnt++;
        held = 0;
      end else begin
        held     = 1;
        held_val = {bus.out_data, bus.out_carry, bus.out_zero};
      end
    end else begin
      held = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_mode   = SH_LSL;
    bus.in_shamt  = 3'd0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b1;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'd0);
    check("rst_out_carry", 32'(bus.out_carry), 32'd0);
    check("rst_out_zero",  32'(bus.out_zero),  32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("in_ready_after_rst", 32'(bus.in_ready), 32'd1);

    // LSL shamt=2 with latency check
    send(3'd0, 3'd2, 8'b11001100);
    bus.in_valid = 1'b0;
    check("lat1_a", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat1_b", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat1_c", 32'(bus.out_valid), 32'd1);
    drain();

    // ASR / LSR, ROR / ROL
    send(3'd2, 3'd3, 8'b10010000);
    send(3'd1, 3'd3, 8'b10010000);
    send(3'd4, 3'd1, 8'b00000001);
    send(3'd3, 3'd7, 8'b00000001);
    bus.in_valid = 1'b0;
    drain();

    // Zero result and shamt=0 in every mode, including reserved codes
    send(3'd1, 3'd4, 8'h0F);
    for (int m = 0; m < 8; m++) send(3'(m), 3'd0, 8'hA5);
    bus.in_valid = 1'b0;
    drain();

    // Back-to-back with a 3-cycle output stall
    saw_stall = 0;
    fork
      begin
        send(3'd0, 3'd1, 8'h81);
        send(3'd1, 3'd2, 8'hF0);
        send(3'd2, 3'd5, 8'h80);
        send(3'd3, 3'd3, 8'h96);
        send(3'd4, 3'd6, 8'h3C);
        send(3'd5, 3'd4, 8'h1B);
        send(3'd7, 3'd5, 8'h5A);
        send(3'd6, 3'd2, 8'hC3);
        bus.in_valid = 1'b0;
      end
      begin
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();
    check("stall_seen", 32'(saw_stall), 32'd1);
    check("count_in_order", 32'(out_cnt), 32'(sent_cnt));

    // Random ops against random output back-pressure
    fork
      begin
        for (int i = 0; i < 24; i++)
          send(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 8'($urandom));
        bus.in_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 40; i++) begin
          @(posedge clk);
          #1 bus.out_ready = 1'($urandom_range(0, 1));
        end
        bus.out_ready = 1'b1;
      end
    join
    bus.out_ready = 1'b1;
    drain();
    check("count_random", 32'(out_cnt), 32'(sent_cnt));

    // Reset with two ops in flight
    send(3'd0, 3'd1, 8'h11);
    send(3'd3, 3'd2, 8'h22);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_out_data",  32'(bus.out_data),  32'd0);
    check("midrst_out_carry", 32'(bus.out_carry), 32'd0);
    check("midrst_out_zero",  32'(bus.out_zero),  32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("in_ready_after_rst2", 32'(bus.in_ready), 32'd1);
    send(3'd4, 3'd3, 8'h0B);
    bus.in_valid = 1'b0;
    check("lat6_a", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat6_b", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat6_c", 32'(bus.out_valid), 32'd1);
    drain();
    repeat (3) @(posedge clk);
    #1;
    check("idle_out_valid", 32'(bus.out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
